// File: rtl/uart_sram_transmitter_pkg.sv
// Shared definitions for the SRAM-to-UART block transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 11-bit frame).
package uart_sram_transmitter_pkg;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_ISSUE,
        S_TX_WAIT,
        S_TX_LATCH,
        S_TX_HIGH,
        S_TX_LOW,
        S_TX_DONE
    } tx_state_type;

    // Cycles from address presented to read data valid at the SRAM controller.
    localparam int TX_SRAM_READ_LATENCY = 2;

`ifdef UART_TX_PARITY_EN
    localparam int TX_FRAME_BITS = 11;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    localparam int TX_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// One-byte UART serializer: start bit, 8 data bits LSB first, [parity], stop bit.
// Ready is high when idle and also in the last cycle of the stop bit, so a Load
// presented then starts the next frame with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx_serializer
    import uart_sram_transmitter_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic       Clock_50,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] Data,
    output logic       Ready,
    output logic       TX_O
);

    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W  = $clog2(TX_FRAME_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(TX_FRAME_BITS - 1);

    logic                     active;
    logic [BAUD_W-1:0]        baud_cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [TX_FRAME_BITS-2:0] shift;
    logic [TX_FRAME_BITS-2:0] payload;
    logic                     bit_end;
    logic                     frame_end;
    logic                     accept;

    // Everything after the start bit, shifted out LSB first.
`ifdef UART_TX_PARITY_EN
    assign payload = {1'b1, even_parity(Data), Data};
`else
    assign payload = {1'b1, Data};
`endif

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = (bit_cnt == BIT_LAST) && bit_end;
    assign Ready     = !active || frame_end;
    assign accept    = Load && Ready;

    // Frame control: baud and bit counters and the line driver.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            active   <= 1'b0;
            TX_O     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            active   <= 1'b1;
            TX_O     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    active <= 1'b0;
                    TX_O   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    TX_O    <= shift[0];
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Payload shift register; ones fill from the top so the line idles high.
    always_ff @(posedge Clock_50) begin
        if (accept) begin
            shift <= payload;
        end else if (active && bit_end) begin
            shift <= {1'b1, shift[TX_FRAME_BITS-2:1]};
        end
    end

endmodule

// File: rtl/uart_sram_transmitter.sv
// Streams a block of 16-bit SRAM words out of the UART transmit pin, high byte
// first. One word is fetched per pass through ISSUE/WAIT/LATCH; the high byte
// is handed to the serializer straight from the read data in LATCH, the low
// byte is buffered and handed over in the high byte's final stop-bit cycle.
// Optional feature macro: UART_TX_PARITY_EN (even parity, 11-bit frames).
module uart_sram_transmitter
    import uart_sram_transmitter_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

    // Extra WAIT cycles beyond the first, so LATCH lines up with valid data.
    localparam logic [1:0] WAIT_LAST = 2'(TX_SRAM_READ_LATENCY - 2);

    tx_state_type state;
    logic [17:0]  remaining;
    logic [7:0]   low_byte;
    logic [1:0]   wait_cnt;
    logic         ser_load;
    logic         ser_ready;
    logic [7:0]   ser_data;

    assign SRAM_we_n = 1'b1;

    // Serializer feed: high byte directly from SRAM in LATCH, low byte from the buffer in HIGH.
    always_comb begin
        ser_load = 1'b0;
        ser_data = low_byte;
        case (state)
            S_TX_LATCH: begin
                ser_load = 1'b1;
                ser_data = SRAM_read_data[15:8];
            end
            S_TX_HIGH: ser_load = 1'b1;
            default: ;
        endcase
    end

    // Transfer sequencer with registered address, Busy and Done.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state        <= S_TX_IDLE;
            SRAM_address <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_TX_IDLE: begin
                    if (Start) begin
                        SRAM_address <= Base_address;
                        remaining    <= Word_count;
                        Busy         <= 1'b1;
                        if (Word_count == 18'd0) begin
                            state <= S_TX_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= S_TX_ISSUE;
                        end
                    end
                end
                S_TX_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_TX_LATCH;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_TX_LATCH: begin
                    low_byte <= SRAM_read_data[7:0];
                    state    <= S_TX_HIGH;
                end
                S_TX_HIGH: begin
                    // Ready here means the high byte is in its last stop cycle and the low byte was just taken.
                    if (ser_ready) begin
                        state <= S_TX_LOW;
                    end
                end
                S_TX_LOW: begin
                    if (ser_ready) begin
                        SRAM_address <= SRAM_address + 18'd1;
                        remaining    <= remaining - 18'd1;
                        if (remaining == 18'd1) begin
                            state <= S_TX_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= S_TX_ISSUE;
                        end
                    end
                end
                S_TX_DONE: begin
                    Busy  <= 1'b0;
                    state <= S_TX_IDLE;
                end
                default: state <= S_TX_IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_serializer (
        .Clock_50 (Clock_50),
        .Reset    (Reset),
        .Load     (ser_load),
        .Data     (ser_data),
        .Ready    (ser_ready),
        .TX_O     (UART_TX_O)
    );

endmodule

// File: tb/tb_uart_sram_transmitter.sv
// Scoreboard bench for uart_sram_transmitter with CLOCKS_PER_BIT = 4.
// Expected frames (byte + first start-bit cycle) and Done cycles are queued when
// a transfer is started; monitors decode the serial line and Done and compare.
`timescale 1ns/1ps
module tb_uart_sram_transmitter;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic        Clock_50 = 1'b0;
    logic        Reset;
    logic        Start;
    logic [17:0] Base_address;
    logic [17:0] Word_count;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    int cyc  = 0;
    int vec  = 0;
    int miss = 0;

    frame_t exp_frames[$];
    int     exp_done[$];
    logic [15:0] mem [logic [17:0]];
    logic [15:0] rd_p1;
    bit          mon_en;

    uart_sram_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
        .Clock_50       (Clock_50),
        .Reset          (Reset),
        .Start          (Start),
        .Base_address   (Base_address),
        .Word_count     (Word_count),
        .SRAM_address   (SRAM_address),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_we_n      (SRAM_we_n),
        .UART_TX_O      (UART_TX_O),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #5 Clock_50 = ~Clock_50;

    always @(posedge Clock_50) cyc <= cyc + 1;

    function automatic logic [15:0] mem_read(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'hDEAD;
    endfunction

    // SRAM controller model with two cycles of read latency
    always @(posedge Clock_50) begin
        rd_p1          <= mem_read(SRAM_address);
        SRAM_read_data <= rd_p1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame monitor: mid-bit sampling, compare against the frame queue
    logic [10:0] mon_bits;
    bit          mon_active = 1'b0;
    int          mon_start;
    int          rel;
    frame_t      fe;
    always @(negedge Clock_50) begin
        if (Reset !== 1'b0 || !mon_en) begin
            mon_active = 1'b0;
        end else if (!mon_active && UART_TX_O === 1'b0) begin
            mon_active = 1'b1;
            mon_start  = cyc;
            mon_bits   = '0;
        end
        if (mon_active) begin
            rel = cyc - mon_start;
            if (rel % CPB == CPB / 2) mon_bits[4'(rel / CPB)] = UART_TX_O;
            if (rel == FRAME - 1) begin
                mon_active = 1'b0;
                check("frame_expected", 32'(exp_frames.size() != 0), 32'd1);
                if (exp_frames.size() != 0) begin
                    fe = exp_frames.pop_front();
                    check("frame_start_cycle", 32'(mon_start), 32'(fe.start));
                    check("frame_start_bit", 32'(mon_bits[0]), 32'd0);
                    check("frame_data", 32'(mon_bits[8:1]), 32'(fe.data));
`ifdef UART_TX_PARITY_EN
                    check("frame_parity", 32'(mon_bits[9]), 32'(^fe.data));
`endif
                    check("frame_stop_bit", 32'(mon_bits[FB-1]), 32'd1);
                end
            end
        end
    end

    // Done monitor
    always @(negedge Clock_50) begin
        if (Reset === 1'b0 && Done === 1'b1) begin
            check("done_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
    end

    // Call right after a posedge (+#1); Start is high in cycle p.
    task automatic start_xfer(input logic [17:0] base, input logic [17:0] cnt, output int p);
        Start        = 1'b1;
        Base_address = base;
        Word_count   = cnt;
        p            = cyc;
        @(posedge Clock_50); #1;
        Start        = 1'b0;
        Base_address = 18'h2AAAA;
        Word_count   = 18'd7;
    endtask

    // Advance to the negedge inside cycle t.
    task automatic at_cycle(input int t);
        while (cyc < t || (cyc == t && Clock_50 === 1'b1)) @(negedge Clock_50);
    endtask

    task automatic wait_quiet(input int limit);
        int n = 0;
        while ((exp_frames.size() != 0 || exp_done.size() != 0 || Busy !== 1'b0) && n < limit) begin
            @(negedge Clock_50);
            n++;
        end
        check("drain_in_time", 32'(n < limit), 32'd1);
        @(posedge Clock_50); #1;
    endtask

    function automatic void push_word(input logic [15:0] w, input int first_start);
        exp_frames.push_back('{data: w[15:8], start: first_start});
        exp_frames.push_back('{data: w[7:0], start: first_start + FRAME});
    endfunction

    initial begin
        int p;
        int busy_cycles;
        int low_cycles;
        Reset        = 1'b1;
        Start        = 1'b0;
        Base_address = '0;
        Word_count   = '0;
        mon_en       = 1'b1;
        mem[18'h00010] = 16'hA55A;
        mem[18'h3FFFF] = 16'h1234;
        mem[18'h00000] = 16'hC3E1;
        mem[18'h00020] = 16'h8001;
        mem[18'h00021] = 16'h7E42;
        mem[18'h00030] = 16'hFFFF;
        mem[18'h00040] = 16'h0707;
        mem[18'h00041] = 16'h0007;

        // Reset state
        repeat (3) @(posedge Clock_50);
        @(negedge Clock_50);
        check("rst_tx", 32'(UART_TX_O), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_addr", 32'(SRAM_address), 32'd0);
        check("rst_we_n", 32'(SRAM_we_n), 32'd1);
        @(posedge Clock_50); #1;
        Reset = 1'b0;
        @(posedge Clock_50); #1;

        // One word 0xA55A from 0x00010
        start_xfer(18'h00010, 18'd1, p);
        push_word(16'hA55A, p + 4);
        exp_done.push_back(p + 4 + 2 * FRAME);
        at_cycle(p + 1);
        check("w1_addr", 32'(SRAM_address), 32'h10);
        check("w1_busy", 32'(Busy), 32'd1);
        at_cycle(p + 3);
        check("w1_idle_before_start", 32'(UART_TX_O), 32'd1);
        at_cycle(p + 4);
        check("w1_start_bit", 32'(UART_TX_O), 32'd0);
        wait_quiet(400);
        check("w1_busy_after", 32'(Busy), 32'd0);
        check("w1_addr_after", 32'(SRAM_address), 32'h11);

        // Two words across the address wrap
        start_xfer(18'h3FFFF, 18'd2, p);
        push_word(16'h1234, p + 4);
        push_word(16'hC3E1, p + 4 + 2 * FRAME + 3);
        exp_done.push_back(p + 4 + 4 * FRAME + 3);
        at_cycle(p + 1);
        check("wrap_addr0", 32'(SRAM_address), 32'h3FFFF);
        low_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            at_cycle(p + 4 + 2 * FRAME + c);
            if (UART_TX_O !== 1'b1) low_cycles++;
        end
        check("wrap_gap_high", 32'(low_cycles), 32'd0);
        check("wrap_addr1", 32'(SRAM_address), 32'h00000);
        wait_quiet(800);

        // Zero-length transfer
        start_xfer(18'h00055, 18'd0, p);
        exp_done.push_back(p + 1);
        busy_cycles = 0;
        low_cycles  = 0;
        for (int c = 1; c <= 6; c++) begin
            at_cycle(p + c);
            if (Busy === 1'b1) busy_cycles++;
            if (UART_TX_O !== 1'b1) low_cycles++;
        end
        check("zero_busy_cycles", 32'(busy_cycles), 32'd1);
        check("zero_line_low", 32'(low_cycles), 32'd0);
        wait_quiet(50);

        // Start while busy is ignored
        start_xfer(18'h00020, 18'd2, p);
        push_word(16'h8001, p + 4);
        push_word(16'h7E42, p + 4 + 2 * FRAME + 3);
        exp_done.push_back(p + 4 + 4 * FRAME + 3);
        at_cycle(p + 20);
        @(posedge Clock_50); #1;
        Start        = 1'b1;
        Base_address = 18'h00030;
        Word_count   = 18'd5;
        @(posedge Clock_50); #1;
        Start = 1'b0;
        at_cycle(p + 4 + 2 * FRAME);
        check("ignore_addr", 32'(SRAM_address), 32'h21);
        wait_quiet(800);
        check("ignore_final_addr", 32'(SRAM_address), 32'h22);

        // Reset during data bit 3 of 0x07
        mon_en = 1'b0;
        start_xfer(18'h00040, 18'd1, p);
        at_cycle(p + 21);
        check("abort_bit3_low", 32'(UART_TX_O), 32'd0);
        @(posedge Clock_50); #1;
        Reset = 1'b1;
        at_cycle(p + 23);
        check("abort_tx_high", 32'(UART_TX_O), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_addr", 32'(SRAM_address), 32'd0);
        @(posedge Clock_50); #1;
        Reset = 1'b0;
        repeat (2) @(posedge Clock_50);
        #1;
        mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        // Parity frame for 0x07: parity bit 1, 44-cycle frames
        start_xfer(18'h00041, 18'd1, p);
        push_word(16'h0007, p + 4);
        exp_done.push_back(p + 4 + 2 * FRAME);
        at_cycle(p + 4 + FRAME + 9 * CPB + 2);
        check("parity_bit_07", 32'(UART_TX_O), 32'd1);
        wait_quiet(400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
